bp_cce_hybrid_req_router: RTL and testbench



---
 rtl/bp_me_pkg.sv | 56 +++++
 rtl/bp_cce_hybrid_burst_demux.sv | 54 +++++
 rtl/bsg_dff_reset_en.sv | 20 ++
 rtl/bp_cce_hybrid_req_router.sv | 177 +++++++++++++++++
 tb/tb_bp_cce_hybrid_req_router.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared BedRock request types, router state and beat-count helper
package bp_me_pkg;

    typedef enum int {e_bp_default_cfg = 0} bp_params_e;

    localparam int dword_width_gp  = 64;
    localparam int paddr_width_p   = 40;
    localparam int lce_id_width_p  = 4;
    localparam int cce_id_width_p  = 6;
    localparam int lce_assoc_p     = 8;
    localparam int lce_way_width_lp = $clog2(lce_assoc_p);

    localparam logic [paddr_width_p-1:0] dram_base_addr_gp = 40'h00_8000_0000;

    typedef enum logic [3:0] {
        e_bedrock_req_rd    = 4'd0,
        e_bedrock_req_wr    = 4'd1,
        e_bedrock_req_uc_rd = 4'd2,
        e_bedrock_req_uc_wr = 4'd3
    } bp_bedrock_req_type_e;

    typedef struct packed {
        logic [cce_id_width_p-1:0]   cce_id;
        logic [lce_id_width_p-1:0]   lce_id;
        logic [lce_way_width_lp-1:0] way_id;
        logic [paddr_width_p-1:0]    addr;
        logic [2:0]                  size;
        logic [3:0]                  msg_type;
    } bp_bedrock_lce_req_header_s;

    localparam int lce_req_msg_header_width_lp = $bits(bp_bedrock_lce_req_header_s);

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_header = 2'd1,
        e_data   = 2'd2
    } bp_cce_hybrid_router_state_e;

    function automatic int bp_cfg_paddr_width_f(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return paddr_width_p;
            default:          return paddr_width_p;
        endcase
    endfunction

    // msg_size encodes 2^size bytes; a burst never carries fewer than one beat
    function automatic logic [7:0] bp_cce_hybrid_beats_f(input logic [2:0] msg_size,
                                                         input int data_width);
        int bits;
        int beats;
        bits  = 8 << msg_size;
        beats = bits / data_width;
        return (beats < 1) ? 8'd1 : beats[7:0];
    endfunction

endpackage

// File: rtl/bp_cce_hybrid_burst_demux.sv
// rtl/bp_cce_hybrid_burst_demux.sv - combinational 1-to-2 burst channel demux (sel_i=1 picks uncached)
module bp_cce_hybrid_burst_demux #(
    parameter int header_width_p = 1,
    parameter int data_width_p   = 1
) (
    input  logic                      sel_i,

    input  logic [header_width_p-1:0] header_i,
    input  logic                      header_v_i,
    output logic                      header_ready_and_o,
    input  logic                      has_data_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic                      data_v_i,
    output logic                      data_ready_and_o,
    input  logic                      last_i,

    output logic [header_width_p-1:0] coh_header_o,
    output logic                      coh_header_v_o,
    input  logic                      coh_header_ready_and_i,
    output logic                      coh_has_data_o,
    output logic [data_width_p-1:0]   coh_data_o,
    output logic                      coh_data_v_o,
    input  logic                      coh_data_ready_and_i,
    output logic                      coh_last_o,

    output logic [header_width_p-1:0] uc_header_o,
    output logic                      uc_header_v_o,
    input  logic                      uc_header_ready_and_i,
    output logic                      uc_has_data_o,
    output logic [data_width_p-1:0]   uc_data_o,
    output logic                      uc_data_v_o,
    input  logic                      uc_data_ready_and_i,
    output logic                      uc_last_o
);

    // The unselected side sees all-zero payload so it never observes a stray burst
    assign coh_header_o   = sel_i ? '0 : header_i;
    assign coh_header_v_o = ~sel_i & header_v_i;
    assign coh_has_data_o = ~sel_i & has_data_i;
    assign coh_data_v_o   = ~sel_i & data_v_i;
    assign coh_data_o     = coh_data_v_o ? data_i : '0;
    assign coh_last_o     = coh_data_v_o & last_i;

    assign uc_header_o    = sel_i ? header_i : '0;
    assign uc_header_v_o  = sel_i & header_v_i;
    assign uc_has_data_o  = sel_i & has_data_i;
    assign uc_data_v_o    = sel_i & data_v_i;
    assign uc_data_o      = uc_data_v_o ? data_i : '0;
    assign uc_last_o      = uc_data_v_o & last_i;

    assign header_ready_and_o = sel_i ? uc_header_ready_and_i : coh_header_ready_and_i;
    assign data_ready_and_o   = sel_i ? uc_data_ready_and_i   : coh_data_ready_and_i;

endmodule

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with asynchronous active-low clear
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_hybrid_req_router.sv
// rtl/bp_cce_hybrid_req_router.sv - routes LCE request bursts to coherent or uncached pipe; BP_CCE_HYBRID_ROUTER_LEN_CHECK_EN adds beat-count checker
module bp_cce_hybrid_req_router
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         lce_data_width_p = dword_width_gp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [lce_req_msg_header_width_lp-1:0] lce_req_header_i,
    input  logic                                   lce_req_header_v_i,
    output logic                                   lce_req_header_ready_and_o,
    input  logic                                   lce_req_has_data_i,
    input  logic [lce_data_width_p-1:0]            lce_req_data_i,
    input  logic                                   lce_req_data_v_i,
    output logic                                   lce_req_data_ready_and_o,
    input  logic                                   lce_req_last_i,

    output logic [lce_req_msg_header_width_lp-1:0] coh_header_o,
    output logic                                   coh_header_v_o,
    input  logic                                   coh_header_ready_and_i,
    output logic                                   coh_has_data_o,
    output logic [lce_data_width_p-1:0]            coh_data_o,
    output logic                                   coh_data_v_o,
    input  logic                                   coh_data_ready_and_i,
    output logic                                   coh_last_o,

    output logic [lce_req_msg_header_width_lp-1:0] uc_header_o,
    output logic                                   uc_header_v_o,
    input  logic                                   uc_header_ready_and_i,
    output logic                                   uc_has_data_o,
    output logic [lce_data_width_p-1:0]            uc_data_o,
    output logic                                   uc_data_v_o,
    input  logic                                   uc_data_ready_and_i,
    output logic                                   uc_last_o,

    output logic                                   idle_o,
    output logic                                   len_err_o
);

    localparam int paddr_width_lp = bp_cfg_paddr_width_f(bp_params_p);

    typedef struct packed {
        bp_bedrock_lce_req_header_s header;
        logic                       has_data;
        logic                       uc;
    } hdr_reg_s;

    bp_cce_hybrid_router_state_e state_r, state_n;
    bp_bedrock_lce_req_header_s  hdr_in;
    hdr_reg_s                    hdr_n, hdr_r;
    logic route_uc, hdr_accept;
    logic dmx_header_v, dmx_header_ready, dmx_data_v, dmx_data_ready;

    assign hdr_in   = lce_req_header_i;
    assign route_uc = (hdr_in.msg_type == 4'(e_bedrock_req_uc_rd))
                    | (hdr_in.msg_type == 4'(e_bedrock_req_uc_wr))
                    | (hdr_in.addr[paddr_width_lp-1:0] < dram_base_addr_gp[paddr_width_lp-1:0]);

    assign hdr_n = '{header: hdr_in, has_data: lce_req_has_data_i, uc: route_uc};

    bsg_dff_reset_en #(.width_p($bits(hdr_reg_s))) hdr_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (hdr_accept),
        .data_i    (hdr_n),
        .data_o    (hdr_r)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n                    = state_r;
        hdr_accept                 = 1'b0;
        lce_req_header_ready_and_o = 1'b0;
        lce_req_data_ready_and_o   = 1'b0;
        dmx_header_v               = 1'b0;
        dmx_data_v                 = 1'b0;
        unique case (state_r)
            e_ready: begin
                lce_req_header_ready_and_o = 1'b1;
                hdr_accept                 = lce_req_header_v_i;
                if (lce_req_header_v_i) state_n = e_header;
            end
            e_header: begin
                dmx_header_v = 1'b1;
                if (dmx_header_ready) state_n = hdr_r.has_data ? e_data : e_ready;
            end
            e_data: begin
                dmx_data_v               = lce_req_data_v_i;
                lce_req_data_ready_and_o = dmx_data_ready;
                if (lce_req_data_v_i & dmx_data_ready & lce_req_last_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    assign idle_o = (state_r == e_ready);

    bp_cce_hybrid_burst_demux #(
        .header_width_p (lce_req_msg_header_width_lp),
        .data_width_p   (lce_data_width_p)
    ) demux (
        .sel_i                  (hdr_r.uc),
        .header_i               (hdr_r.header),
        .header_v_i             (dmx_header_v),
        .header_ready_and_o     (dmx_header_ready),
        .has_data_i             (hdr_r.has_data),
        .data_i                 (lce_req_data_i),
        .data_v_i               (dmx_data_v),
        .data_ready_and_o       (dmx_data_ready),
        .last_i                 (lce_req_last_i),
        .coh_header_o           (coh_header_o),
        .coh_header_v_o         (coh_header_v_o),
        .coh_header_ready_and_i (coh_header_ready_and_i),
        .coh_has_data_o         (coh_has_data_o),
        .coh_data_o             (coh_data_o),
        .coh_data_v_o           (coh_data_v_o),
        .coh_data_ready_and_i   (coh_data_ready_and_i),
        .coh_last_o             (coh_last_o),
        .uc_header_o            (uc_header_o),
        .uc_header_v_o          (uc_header_v_o),
        .uc_header_ready_and_i  (uc_header_ready_and_i),
        .uc_has_data_o          (uc_has_data_o),
        .uc_data_o              (uc_data_o),
        .uc_data_v_o            (uc_data_v_o),
        .uc_data_ready_and_i    (uc_data_ready_and_i),
        .uc_last_o              (uc_last_o)
    );

`ifdef BP_CCE_HYBRID_ROUTER_LEN_CHECK_EN
    logic [7:0] cnt_r, cnt_inc, beats_exp;
    logic       len_err_r, data_hs, enter_data;

    assign data_hs    = (state_r == e_data) & lce_req_data_v_i & dmx_data_ready;
    assign enter_data = (state_r == e_header) & dmx_header_ready & hdr_r.has_data;
    assign cnt_inc    = cnt_r + 8'd1;
    assign beats_exp  = bp_cce_hybrid_beats_f(hdr_r.header.size, lce_data_width_p);

    // Flag a short burst on last, or a long one once the expected count is hit without last
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r     <= '0;
            len_err_r <= 1'b0;
        end else begin
            if (enter_data) begin
                cnt_r <= '0;
            end else if (data_hs) begin
                cnt_r <= cnt_inc;
            end
            if (data_hs & (lce_req_last_i ? (cnt_inc != beats_exp) : (cnt_inc >= beats_exp))) begin
                len_err_r <= 1'b1;
            end
        end
    end

    assign len_err_o = len_err_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i & data_hs & lce_req_last_i) begin
            assert (cnt_inc == beats_exp) else $warning("router burst length mismatch");
        end
    end
`endif
`else
    assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_req_router.sv
// tb/tb_bp_cce_hybrid_req_router.sv - directed self-checking bench for bp_cce_hybrid_req_router
module tb_bp_cce_hybrid_req_router;
    import bp_me_pkg::*;

    localparam int dw = 64;

    logic clk = 1'b0;
    logic rst_n;
    bp_bedrock_lce_req_header_s hdr_drv;
    logic hv, hd, dv, lst;
    logic [dw-1:0] din;
    logic coh_hrdy, coh_drdy, uc_hrdy, uc_drdy;

    logic up_hrdy, up_drdy, idle, len_err;
    logic [lce_req_msg_header_width_lp-1:0] coh_hdr, uc_hdr;
    logic coh_hv, coh_hd, coh_dv, coh_last, uc_hv, uc_hd, uc_dv, uc_last;
    logic [dw-1:0] coh_d, uc_d;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    bp_cce_hybrid_req_router #(.bp_params_p(e_bp_default_cfg), .lce_data_width_p(dw)) dut (
        .clk_i                      (clk),
        .reset_n_i                  (rst_n),
        .lce_req_header_i           (hdr_drv),
        .lce_req_header_v_i         (hv),
        .lce_req_header_ready_and_o (up_hrdy),
        .lce_req_has_data_i         (hd),
        .lce_req_data_i             (din),
        .lce_req_data_v_i           (dv),
        .lce_req_data_ready_and_o   (up_drdy),
        .lce_req_last_i             (lst),
        .coh_header_o               (coh_hdr),
        .coh_header_v_o             (coh_hv),
        .coh_header_ready_and_i     (coh_hrdy),
        .coh_has_data_o             (coh_hd),
        .coh_data_o                 (coh_d),
        .coh_data_v_o               (coh_dv),
        .coh_data_ready_and_i       (coh_drdy),
        .coh_last_o                 (coh_last),
        .uc_header_o                (uc_hdr),
        .uc_header_v_o              (uc_hv),
        .uc_header_ready_and_i      (uc_hrdy),
        .uc_has_data_o              (uc_hd),
        .uc_data_o                  (uc_d),
        .uc_data_v_o                (uc_dv),
        .uc_data_ready_and_i        (uc_drdy),
        .uc_last_o                  (uc_last),
        .idle_o                     (idle),
        .len_err_o                  (len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bp_bedrock_lce_req_header_s mkhdr(input logic [3:0] t, input logic [2:0] sz,
                                                         input logic [39:0] a);
        bp_bedrock_lce_req_header_s h;
        h          = '0;
        h.msg_type = t;
        h.size     = sz;
        h.addr     = a;
        h.lce_id   = 4'h3;
        h.cce_id   = 6'h05;
        h.way_id   = 3'h2;
        return h;
    endfunction

    // Present a header for one cycle; returns one cycle after the input handshake, settled
    task automatic send_hdr(input bp_bedrock_lce_req_header_s h, input logic has);
        hdr_drv = h;
        hd      = has;
        hv      = 1'b1;
        tick();
        hv = 1'b0;
        hd = 1'b0;
        #1;
    endtask

    initial begin
        bp_bedrock_lce_req_header_s h;
        logic [dw-1:0] d;

        rst_n = 1'b0; hdr_drv = '0; hv = 0; hd = 0; dv = 0; lst = 0; din = '0;
        coh_hrdy = 1; coh_drdy = 1; uc_hrdy = 1; uc_drdy = 1;
        #3;
        chk1("rst_hdr_ready", up_hrdy, 1'b1);
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_coh_hv", coh_hv, 1'b0);
        chk1("rst_uc_hv", uc_hv, 1'b0);
        chk1("rst_data_ready", up_drdy, 1'b0);
        chk1("rst_len_err", len_err, 1'b0);
        chk("rst_coh_hdr", 64'(coh_hdr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // coherent read, no data
        h = mkhdr(4'(e_bedrock_req_rd), 3'd3, 40'h00_8000_0040);
        send_hdr(h, 1'b0);
        chk1("cr_coh_hv", coh_hv, 1'b1);
        chk("cr_coh_hdr", 64'(coh_hdr), 64'(h));
        chk1("cr_uc_hv", uc_hv, 1'b0);
        chk1("cr_coh_hd", coh_hd, 1'b0);
        chk1("cr_busy", idle, 1'b0);
        chk1("cr_up_hrdy", up_hrdy, 1'b0);
        tick();
        chk1("cr_idle_after", idle, 1'b1);
        chk1("cr_coh_hv_after", coh_hv, 1'b0);

        // uncached 64B write, 8 beats, stall on beat 5
        h = mkhdr(4'(e_bedrock_req_uc_wr), 3'd6, 40'h00_8000_1000);
        send_hdr(h, 1'b1);
        chk1("uw_uc_hv", uc_hv, 1'b1);
        chk1("uw_coh_hv", coh_hv, 1'b0);
        chk1("uw_uc_hd", uc_hd, 1'b1);
        chk("uw_uc_hdr", 64'(uc_hdr), 64'(h));
        tick();
        for (int i = 0; i < 8; i++) begin
            d   = 64'hA5A5_0000_0000_0000 | 64'(i);
            din = d;
            dv  = 1'b1;
            lst = (i == 7);
            #1;
            if (i == 4) begin
                uc_drdy = 1'b0;
                #1;
                chk1("uw_stall_up_rdy", up_drdy, 1'b0);
                chk1("uw_stall_v", uc_dv, 1'b1);
                tick();
                chk("uw_stall_hold", uc_d, d);
                uc_drdy = 1'b1;
                #1;
            end
            chk("uw_beat_data", uc_d, d);
            chk1("uw_beat_last", uc_last, 1'(i == 7));
            chk1("uw_beat_coh_v", coh_dv, 1'b0);
            chk1("uw_beat_up_rdy", up_drdy, 1'b1);
            tick();
        end
        dv = 1'b0; lst = 1'b0;
        #1;
        chk1("uw_idle", idle, 1'b1);
        chk1("uw_len_err", len_err, 1'b0);
        chk1("uw_uc_dv_off", uc_dv, 1'b0);

        // below-DRAM read goes uncached
        h = mkhdr(4'(e_bedrock_req_rd), 3'd3, 40'h00_0010_0000);
        send_hdr(h, 1'b0);
        chk1("lo_uc_hv", uc_hv, 1'b1);
        chk1("lo_coh_hv", coh_hv, 1'b0);
        tick();
        chk1("lo_idle", idle, 1'b1);

        // header backpressure for 5 cycles while upstream presents another header
        coh_hrdy = 1'b0;
        h = mkhdr(4'(e_bedrock_req_rd), 3'd3, 40'h00_8000_0080);
        send_hdr(h, 1'b0);
        hdr_drv = mkhdr(4'(e_bedrock_req_wr), 3'd6, 40'h00_9999_0000);
        hv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hdr_stable", 64'(coh_hdr), 64'(h));
            chk1("bp_hv_stable", coh_hv, 1'b1);
            chk1("bp_up_hrdy", up_hrdy, 1'b0);
            tick();
        end
        hv = 1'b0;
        coh_hrdy = 1'b1;
        tick();
        chk1("bp_idle", idle, 1'b1);

        // short burst: 64B write with last on beat 4
        h = mkhdr(4'(e_bedrock_req_uc_wr), 3'd6, 40'h00_8000_3000);
        send_hdr(h, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            din = 64'h0000_0000_BEEF_0000 | 64'(i);
            dv  = 1'b1;
            lst = (i == 3);
            tick();
        end
        dv = 1'b0; lst = 1'b0;
        #1;
        chk1("le_idle", idle, 1'b1);
`ifdef BP_CCE_HYBRID_ROUTER_LEN_CHECK_EN
        chk1("le_err_set", len_err, 1'b1);
`else
        chk1("le_err_tied", len_err, 1'b0);
`endif
        h = mkhdr(4'(e_bedrock_req_rd), 3'd3, 40'h00_8000_0100);
        send_hdr(h, 1'b0);
        tick();
`ifdef BP_CCE_HYBRID_ROUTER_LEN_CHECK_EN
        chk1("le_err_held", len_err, 1'b1);
`else
        chk1("le_err_still_0", len_err, 1'b0);
`endif

        // reset asserted during beat 3 of a coherent write
        h = mkhdr(4'(e_bedrock_req_wr), 3'd6, 40'h00_8000_2000);
        send_hdr(h, 1'b1);
        chk1("rb_coh_hd", coh_hd, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            din = 64'h1111_0000_0000_0000 | 64'(i);
            dv  = 1'b1;
            tick();
        end
        din = 64'h1111_0000_0000_0002;
        #1;
        chk1("rb_beat3_v", coh_dv, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rb_coh_dv", coh_dv, 1'b0);
        chk("rb_coh_d", coh_d, 64'h0);
        chk1("rb_coh_hv", coh_hv, 1'b0);
        chk1("rb_up_hrdy", up_hrdy, 1'b1);
        chk1("rb_up_drdy", up_drdy, 1'b0);
        chk1("rb_idle", idle, 1'b1);
        chk1("rb_len_err", len_err, 1'b0);
        tick();
        tick();
        dv = 1'b0;
        rst_n = 1'b1;
        tick();
        h = mkhdr(4'(e_bedrock_req_rd), 3'd3, 40'h00_8000_0200);
        send_hdr(h, 1'b0);
        chk1("ra_coh_hv", coh_hv, 1'b1);
        chk("ra_coh_hdr", 64'(coh_hdr), 64'(h));
        tick();
        chk1("ra_idle", idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
